p_to_s: RTL and testbench

- Parallel-to-serial converter that accepts one wide word of LANES lanes and emits the lanes one per beat, lane 0 first.
- It is the transmit-side inverse of the serial-to-parallel packer: a word packed from N serial beats is turned back into the same N beats in the same order.
- Sits between wide symbol/word producers and narrow per-lane streaming consumers.
- Has a one-word holding buffer, so back-to-back words stream at full rate (one lane per clock) with no bubble.

---
 rtl/p_to_s.sv | 78 +++++++
 tb/tb_p_to_s.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/p_to_s.sv
// Parallel-to-serial: emits one LANES-wide word as LANES beats, lane 0 first; lane 0 appears the cycle after acceptance.
// One-word hold buffer gives gapless back-to-back streaming; o_ready low freezes the current lane, i_ready drops while hold is full.
module p_to_s #(
   parameter int WIDTH = 8,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH*LANES-1:0] i_data,
   input  logic                   i_valid,
   output logic                   i_ready,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic                   o_last
);

   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [CW-1:0] LAST = CW'(LANES - 1);

   logic [WIDTH*LANES-1:0] act_data;
   logic [WIDTH*LANES-1:0] hold_data;
   logic                   act_valid;
   logic                   hold_valid;
   logic [CW-1:0]          cnt;
   logic                   in_xfer;
   logic                   out_xfer;
   logic                   fin;

   assign in_xfer  = i_valid & i_ready;
   assign out_xfer = act_valid & o_ready;
   assign fin      = out_xfer & (cnt == LAST);

   assign i_ready = !hold_valid;
   assign o_valid = act_valid;
   assign o_last  = act_valid & (cnt == LAST);

   always_comb begin
      o_data = '0;
      for (int k = 0; k < LANES; k++) begin
         if (cnt == CW'(k)) o_data = act_data[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_data   <= '0;
         hold_data  <= '0;
         act_valid  <= 1'b0;
         hold_valid <= 1'b0;
         cnt        <= '0;
      end else if (fin) begin
         // Word finished: refill from hold first, else directly from input, else go idle.
         cnt <= '0;
         if (hold_valid) begin
            act_data   <= hold_data;
            hold_valid <= 1'b0;
         end else if (in_xfer) begin
            act_data <= i_data;
         end else begin
            act_valid <= 1'b0;
         end
      end else begin
         if (out_xfer) cnt <= cnt + CW'(1);
         if (in_xfer) begin
            if (!act_valid) begin
               act_data  <= i_data;
               act_valid <= 1'b1;
               cnt       <= '0;
            end else begin
               hold_data  <= i_data;
               hold_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_p_to_s.sv
// Directed bench for p_to_s: a 4-lane instance for the main scenarios and a 1-lane instance for the FIFO-like case.
module tb_p_to_s;

   logic        clk;
   logic        rst;
   logic [31:0] i_data;
   logic        i_valid;
   logic        i_ready;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        o_ready;
   logic        o_last;

   logic [7:0]  d1_i_data;
   logic        d1_i_valid;
   logic        d1_i_ready;
   logic [7:0]  d1_o_data;
   logic        d1_o_valid;
   logic        d1_o_ready;
   logic        d1_o_last;

   int checks = 0;
   int errors = 0;

   p_to_s #(.WIDTH(8), .LANES(4)) dut (
      .clk(clk), .rst(rst),
      .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
      .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last)
   );

   p_to_s #(.WIDTH(8), .LANES(1)) dut1 (
      .clk(clk), .rst(rst),
      .i_data(d1_i_data), .i_valid(d1_i_valid), .i_ready(d1_i_ready),
      .o_data(d1_o_data), .o_valid(d1_o_valid), .o_ready(d1_o_ready), .o_last(d1_o_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [7:0] d, input logic last);
      chk({tag, " o_valid"}, 32'(o_valid), 32'd1);
      chk({tag, " o_data"}, 32'(o_data), 32'(d));
      chk({tag, " o_last"}, 32'(o_last), 32'(last));
   endtask

   initial begin
      logic [7:0] b2b [8];
      logic       b2b_rdy [8];
      logic [7:0] bp [6];
      logic [7:0] d1_words [2];
      int tx;
      int rx;

      b2b      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      b2b_rdy  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      bp       = '{8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      d1_words = '{8'h5A, 8'hA5};

      rst = 1'b0; i_data = '0; i_valid = 1'b0; o_ready = 1'b0;
      d1_i_data = '0; d1_i_valid = 1'b0; d1_o_ready = 1'b0;

      // Reset state
      #2;
      chk("rst o_valid", 32'(o_valid), 32'd0);
      chk("rst o_last", 32'(o_last), 32'd0);
      chk("rst o_data", 32'(o_data), 32'd0);
      chk("rst d1 o_valid", 32'(d1_o_valid), 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst i_ready", 32'(i_ready), 32'd1);

      // Single word
      i_data = 32'hDDCCBBAA; i_valid = 1'b1; o_ready = 1'b1;
      @(negedge clk); i_valid = 1'b0;
      beat("single 0", 8'hAA, 1'b0);
      @(negedge clk); beat("single 1", 8'hBB, 1'b0);
      @(negedge clk); beat("single 2", 8'hCC, 1'b0);
      @(negedge clk); beat("single 3", 8'hDD, 1'b1);
      @(negedge clk); chk("single idle", 32'(o_valid), 32'd0);

      // Back-to-back words
      i_data = 32'h44332211; i_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) i_data = 32'h88776655;
         else i_valid = 1'b0;
         beat($sformatf("b2b %0d", k), b2b[k], (k == 3) || (k == 7));
         chk($sformatf("b2b i_ready %0d", k), 32'(i_ready), 32'(b2b_rdy[k]));
      end
      @(negedge clk); chk("b2b idle", 32'(o_valid), 32'd0);

      // Input transfer in the same cycle as fin, hold empty
      i_data = 32'hDDCCBBAA; i_valid = 1'b1;
      @(negedge clk); i_valid = 1'b0; beat("sim AA", 8'hAA, 1'b0);
      @(negedge clk); beat("sim BB", 8'hBB, 1'b0);
      @(negedge clk); beat("sim CC", 8'hCC, 1'b0);
      @(negedge clk); beat("sim DD", 8'hDD, 1'b1);
      chk("sim i_ready", 32'(i_ready), 32'd1);
      i_data = 32'h0F0E0D0C; i_valid = 1'b1;
      @(negedge clk); i_valid = 1'b0; beat("sim 0C", 8'h0C, 1'b0);
      @(negedge clk); beat("sim 0D", 8'h0D, 1'b0);
      @(negedge clk); beat("sim 0E", 8'h0E, 1'b0);
      @(negedge clk); beat("sim 0F", 8'h0F, 1'b1);
      @(negedge clk); chk("sim idle", 32'(o_valid), 32'd0);

      // Backpressure on lane BB with a second word captured into hold
      i_data = 32'hDDCCBBAA; i_valid = 1'b1;
      @(negedge clk); i_valid = 1'b0; beat("bp AA", 8'hAA, 1'b0);
      @(negedge clk); beat("bp BB", 8'hBB, 1'b0);
      o_ready = 1'b0; i_data = 32'h44332211; i_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); i_valid = 1'b0;
         beat($sformatf("bp stall %0d", k), 8'hBB, 1'b0);
         chk($sformatf("bp stall i_ready %0d", k), 32'(i_ready), 32'd0);
      end
      o_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         beat($sformatf("bp drain %0d", k), bp[k], (k == 1) || (k == 5));
         chk($sformatf("bp i_ready %0d", k), 32'(i_ready), (k < 2) ? 32'd0 : 32'd1);
      end
      @(negedge clk); chk("bp idle", 32'(o_valid), 32'd0);

      // Asynchronous reset mid-word, with a word held
      i_data = 32'hDDCCBBAA; i_valid = 1'b1;
      @(negedge clk); i_valid = 1'b0; beat("ar AA", 8'hAA, 1'b0);
      @(negedge clk); beat("ar BB", 8'hBB, 1'b0);
      o_ready = 1'b0; i_data = 32'h44332211; i_valid = 1'b1;
      @(negedge clk); i_valid = 1'b0;
      chk("ar held i_ready", 32'(i_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("ar o_valid", 32'(o_valid), 32'd0);
      chk("ar i_ready", 32'(i_ready), 32'd1);
      chk("ar o_data", 32'(o_data), 32'd0);
      @(negedge clk); rst = 1'b1; o_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("ar quiet %0d", k), 32'(o_valid), 32'd0);
      end

      // LANES=1 stream with random o_ready
      tx = 0; rx = 0;
      for (int cyc = 0; cyc < 60 && rx < 2; cyc++) begin
         @(negedge clk);
         d1_o_ready = 1'($urandom_range(0, 1));
         if (d1_o_valid) chk($sformatf("d1 o_last %0d", rx), 32'(d1_o_last), 32'd1);
         if (d1_o_valid && d1_o_ready) begin
            chk($sformatf("d1 o_data %0d", rx), 32'(d1_o_data), 32'(d1_words[rx]));
            rx++;
         end
         if (tx < 2) begin
            d1_i_valid = 1'b1;
            d1_i_data  = d1_words[tx];
            if (d1_i_ready) tx++;
         end else begin
            d1_i_valid = 1'b0;
         end
      end
      chk("d1 beats received", 32'(rx), 32'd2);
      d1_i_valid = 1'b0; d1_o_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("d1 idle", 32'(d1_o_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
